rv_mem_arb: RTL and testbench

Arbiter and sequencer for the single-port unified memory of the multicycle RISC-V core. It shares the memory between two requesters: the core (fetch and load/store traffic) and a program-loader/debug port. Each port uses a request/acknowledge handshake. The block issues one memory access at a time, waits a fixed memory latency, and returns read data. The core has priority, but the loader has a bounded wait (starvation guard).

---
 rtl/rv_mem_pkg.sv | 26 ++
 rtl/rv_mem_arb_if.sv | 31 +++
 rtl/rv_arb_starve_cnt.sv | 31 +++
 rtl/rv_mem_arb.sv | 92 +++++++++
 tb/tb_rv_mem_arb.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter.
//   state_e : arbiter FSM states
//   OWNER_* : encoding of the owner output / grant winner
//   req_t   : request fields latched at grant time (we, addr, wdata)
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_LDR  = 1'b1;

  localparam int REQ_AW = 32;
  localparam int REQ_DW = 32;

  typedef struct packed {
    logic              we;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rv_mem_arb_if.sv
// Bus bundle for rv_mem_arb: core port (c_*), loader port (l_*), memory
// port (mem_*) and status (busy, owner).
//   slave  : arbiter view (requests in, acks/rdata out, drives memory)
//   master : environment view (requesters plus memory model)
interface rv_mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req, c_we, c_ack;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          l_req, l_we, l_ack;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output c_ack, c_rdata, l_ack, l_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  c_ack, c_rdata, l_ack, l_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, owner
  );
endinterface

// File: rtl/rv_arb_starve_cnt.sv
// Saturating starvation counter for the loader port.
//   l_req      : loader request pending
//   core_grant : core granted this cycle
//   ldr_grant  : loader granted this cycle
//   idle       : arbiter in IDLE
//   force_ldr  : loader has waited MAX_WAIT core grants and must win next
module rv_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic l_req,
  input  logic core_grant,
  input  logic ldr_grant,
  input  logic idle,
  output logic force_ldr
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  // An idle cycle without l_req also covers a core grant made while the
  // loader is quiet, so such grants never count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            cnt <= '0;
    else if (ldr_grant || (idle && !l_req)) cnt <= '0;
    else if (core_grant && !force_ldr)   cnt <= cnt + 1'b1;
  end

  assign force_ldr = (cnt == CW'(MAX_WAIT));
endmodule

// File: rtl/rv_mem_arb.sv
// Arbiter/sequencer for the single-port unified memory.
//   clk, rst : clock, async active-low reset
//   bus      : core and loader request/ack ports, memory port, busy/owner
// One access at a time: IDLE (sample/grant) -> ISSUE (mem_en) ->
// WAIT (MEM_LAT-1 cycles) -> RESP (ack) -> IDLE. Core has priority; the
// loader wins after MAX_WAIT consecutive core grants while it waits.
module rv_mem_arb
  import rv_mem_pkg::*;
#(
  parameter int AW       = REQ_AW,
  parameter int DW       = REQ_DW,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input logic        clk,
  input logic        rst,
  rv_mem_arb_if.slave bus
);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e             state;
  req_t               lat;
  logic               own;
  logic [LW-1:0]      lat_cnt;
  logic [1:0][DW-1:0] rdata;   // indexed by owner
  logic               idle, ldr_win, core_grant, ldr_grant, force_ldr, cap;

  assign idle       = (state == IDLE);
  assign ldr_win    = bus.l_req & (force_ldr | ~bus.c_req);
  assign ldr_grant  = idle & ldr_win;
  assign core_grant = idle & bus.c_req & ~ldr_win;

  // Read data is sampled in the last cycle before RESP.
  assign cap = ((state == ISSUE) && (MEM_LAT == 1)) ||
               ((state == WAIT) && (lat_cnt == '0));

  rv_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk       (clk),
    .rst       (rst),
    .l_req     (bus.l_req),
    .core_grant(core_grant),
    .ldr_grant (ldr_grant),
    .idle      (idle),
    .force_ldr (force_ldr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lat     <= '0;
      own     <= OWNER_CORE;
      lat_cnt <= '0;
      rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.c_req || bus.l_req) begin
          state     <= ISSUE;
          own       <= ldr_win ? OWNER_LDR : OWNER_CORE;
          lat.we    <= ldr_win ? bus.l_we : bus.c_we;
          lat.addr  <= REQ_AW'(ldr_win ? bus.l_addr : bus.c_addr);
          lat.wdata <= REQ_DW'(ldr_win ? bus.l_wdata : bus.c_wdata);
        end
        ISSUE: begin
          if (MEM_LAT > 1) begin
            state   <= WAIT;
            lat_cnt <= LW'(MEM_LAT - 2);
          end else begin
            state <= RESP;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) state <= RESP;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (cap && !lat.we) rdata[own] <= bus.mem_rdata;
    end
  end

  assign bus.mem_en    = (state == ISSUE);
  assign bus.mem_we    = lat.we;
  assign bus.mem_addr  = AW'(lat.addr);
  assign bus.mem_wdata = DW'(lat.wdata);
  assign bus.c_ack     = (state == RESP) && (own == OWNER_CORE);
  assign bus.l_ack     = (state == RESP) && (own == OWNER_LDR);
  assign bus.c_rdata   = rdata[OWNER_CORE];
  assign bus.l_rdata   = rdata[OWNER_LDR];
  assign bus.busy      = !idle;
  assign bus.owner     = own;
endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: two instances (MEM_LAT=1 and MEM_LAT=3) share one
// stimulus set; sel3 picks which one is observed. Directed table, hand
// sequences for starvation/latency/reset, then randomized traffic checked
// against a transaction-timing model.
module tb_rv_mem_arb;
  localparam int AW = 32, DW = 32, MAX_WAIT = 4;
  typedef logic [159:0] cv_t;

  logic clk = 1'b0, rst = 1'b0, init_mem = 1'b0, sel3 = 1'b0;
  always #5 clk = ~clk;

  logic          c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [AW-1:0] c_addr = '0, l_addr = '0;
  logic [DW-1:0] c_wdata = '0, l_wdata = '0;

  rv_mem_arb_if #(.AW(AW), .DW(DW)) if1 ();
  rv_mem_arb_if #(.AW(AW), .DW(DW)) if3 ();

  rv_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(1), .MAX_WAIT(MAX_WAIT)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  rv_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(3), .MAX_WAIT(MAX_WAIT)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  assign if1.c_req = c_req;   assign if3.c_req = c_req;
  assign if1.c_we = c_we;     assign if3.c_we = c_we;
  assign if1.c_addr = c_addr; assign if3.c_addr = c_addr;
  assign if1.c_wdata = c_wdata; assign if3.c_wdata = c_wdata;
  assign if1.l_req = l_req;   assign if3.l_req = l_req;
  assign if1.l_we = l_we;     assign if3.l_we = l_we;
  assign if1.l_addr = l_addr; assign if3.l_addr = l_addr;
  assign if1.l_wdata = l_wdata; assign if3.l_wdata = l_wdata;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'hA000_0000 + 32'(i);
  endfunction

  // Memory models: combinational read, write at the issue edge.
  logic [DW-1:0] mem1 [16];
  logic [DW-1:0] mem3 [16];
  assign if1.mem_rdata = mem1[if1.mem_addr[5:2]];
  assign if3.mem_rdata = mem3[if3.mem_addr[5:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) begin mem1[i] <= init_word(i); mem3[i] <= init_word(i); end
    end else begin
      if (if1.mem_en && if1.mem_we) mem1[if1.mem_addr[5:2]] <= if1.mem_wdata;
      if (if3.mem_en && if3.mem_we) mem3[if3.mem_addr[5:2]] <= if3.mem_wdata;
    end
  end

  // Observed outputs of the selected instance.
  logic          o_cack, o_lack, o_en, o_we, o_busy, o_owner;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata, o_crd, o_lrd;
  assign o_cack  = sel3 ? if3.c_ack     : if1.c_ack;
  assign o_lack  = sel3 ? if3.l_ack     : if1.l_ack;
  assign o_en    = sel3 ? if3.mem_en    : if1.mem_en;
  assign o_we    = sel3 ? if3.mem_we    : if1.mem_we;
  assign o_busy  = sel3 ? if3.busy      : if1.busy;
  assign o_owner = sel3 ? if3.owner     : if1.owner;
  assign o_addr  = sel3 ? if3.mem_addr  : if1.mem_addr;
  assign o_wdata = sel3 ? if3.mem_wdata : if1.mem_wdata;
  assign o_crd   = sel3 ? if3.c_rdata   : if1.c_rdata;
  assign o_lrd   = sel3 ? if3.l_rdata   : if1.l_rdata;

  int nvec = 0, nerr = 0;

  task automatic check(input string name, input cv_t got, input cv_t exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    c_req = 1'b0; l_req = 1'b0; c_we = 1'b0; l_we = 1'b0;
    c_addr = '0; l_addr = '0; c_wdata = '0; l_wdata = '0;
    rst = 1'b0; init_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1 init_mem = 1'b0;
    @(negedge clk);
    check("reset_state", cv_t'({o_cack, o_lack, o_en, o_we, o_busy, o_owner, o_addr, o_wdata, o_crd, o_lrd}), '0);
    rst = 1'b1;
  endtask

  // Directed vectors: ctl = {c_req,c_we,l_req,l_we}; fl = {en,we,c_ack,l_ack,busy,owner}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] ca, cd, la, ld;
    logic [5:0]  fl;
    logic [31:0] ad, crd, lrd;
  } vec_t;
  vec_t tv [18];

  // Randomized traffic vs. a transaction-level model: a grant is decided in
  // each idle cycle, issues one cycle later, acks lat cycles after issue and
  // the arbiter is free again one cycle after the ack.
  task automatic run_random(input int n);
    int lat, cyc, free_at, iss_at, ack_at, wcnt;
    logic m_own, prev_own, m_we, ldr, ca_prev, la_prev;
    logic [31:0] m_addr, m_wdata, pend, e_crd, e_lrd;
    logic [31:0] sh [16];
    lat = sel3 ? 3 : 1;
    for (int i = 0; i < 16; i++) sh[i] = init_word(i);
    cyc = 0; free_at = 0; iss_at = -100; ack_at = -100; wcnt = 0;
    m_own = 1'b0; prev_own = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    pend = '0; e_crd = '0; e_lrd = '0; ca_prev = 1'b0; la_prev = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (!c_req || ca_prev) begin
        if ($urandom_range(0, 2) != 0) begin
          c_req = 1'b1; c_we = 1'($urandom_range(0, 1));
          c_addr = 32'($urandom_range(0, 15)) << 2; c_wdata = $urandom;
        end else c_req = 1'b0;
      end
      if (!l_req || la_prev) begin
        if ($urandom_range(0, 1) != 0) begin
          l_req = 1'b1; l_we = 1'($urandom_range(0, 1));
          l_addr = 32'($urandom_range(0, 15)) << 2; l_wdata = $urandom;
        end else l_req = 1'b0;
      end
      @(negedge clk);
      if (cyc == free_at) begin
        if (c_req || l_req) begin
          ldr = l_req && (wcnt == MAX_WAIT || !c_req);
          if (!l_req || ldr) wcnt = 0;
          else if (wcnt < MAX_WAIT) wcnt++;
          prev_own = m_own; m_own = ldr;
          m_we    = ldr ? l_we : c_we;
          m_addr  = ldr ? l_addr : c_addr;
          m_wdata = ldr ? l_wdata : c_wdata;
          if (m_we) sh[m_addr[5:2]] = m_wdata;
          else      pend = sh[m_addr[5:2]];
          iss_at = cyc + 1; ack_at = cyc + 1 + lat; free_at = cyc + lat + 2;
        end else begin
          wcnt = 0; free_at = cyc + 1;
        end
      end
      if (cyc == ack_at && !m_we) begin
        if (m_own) e_lrd = pend; else e_crd = pend;
      end
      check($sformatf("rand_out_lat%0d_c%0d", lat, cyc),
            cv_t'({o_cack, o_lack, o_en, o_busy, o_owner, o_crd, o_lrd}),
            cv_t'({cyc == ack_at && !m_own, cyc == ack_at && m_own, cyc == iss_at,
                   cyc >= iss_at && cyc <= ack_at, (cyc >= iss_at) ? m_own : prev_own, e_crd, e_lrd}));
      if (cyc == iss_at) begin
        check($sformatf("rand_bus_lat%0d_c%0d", lat, cyc), cv_t'({o_we, o_addr}), cv_t'({m_we, m_addr}));
        if (m_we) check($sformatf("rand_wdata_lat%0d_c%0d", lat, cyc), cv_t'(o_wdata), cv_t'(m_wdata));
      end
      ca_prev = o_cack; la_prev = o_lack;
      cyc++;
    end
    @(posedge clk); #1 c_req = 1'b0; l_req = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  int  ncore;
  logic got_l;

  initial begin
    tv[0]  = '{4'b1000, 32'h10, 32'h0, 32'h0, 32'h0,    6'b000000, 32'h0,  32'h0,        32'h0};
    tv[1]  = '{4'b1000, 32'h10, 32'h0, 32'h0, 32'h0,    6'b100010, 32'h10, 32'h0,        32'h0};
    tv[2]  = '{4'b1000, 32'h10, 32'h0, 32'h0, 32'h0,    6'b001010, 32'h10, 32'hDEADBEEF, 32'h0};
    tv[3]  = '{4'b0000, 32'h0,  32'h0, 32'h0, 32'h0,    6'b000000, 32'h10, 32'hDEADBEEF, 32'h0};
    tv[4]  = '{4'b0011, 32'h0,  32'h0, 32'h4, 32'h1234, 6'b000000, 32'h10, 32'hDEADBEEF, 32'h0};
    tv[5]  = '{4'b0011, 32'h0,  32'h0, 32'h4, 32'h1234, 6'b110011, 32'h4,  32'hDEADBEEF, 32'h0};
    tv[6]  = '{4'b0011, 32'h0,  32'h0, 32'h4, 32'h1234, 6'b010111, 32'h4,  32'hDEADBEEF, 32'h0};
    tv[7]  = '{4'b1000, 32'h4,  32'h0, 32'h0, 32'h0,    6'b010001, 32'h4,  32'hDEADBEEF, 32'h0};
    tv[8]  = '{4'b1000, 32'h4,  32'h0, 32'h0, 32'h0,    6'b100010, 32'h4,  32'hDEADBEEF, 32'h0};
    tv[9]  = '{4'b1000, 32'h4,  32'h0, 32'h0, 32'h0,    6'b001010, 32'h4,  32'h1234,     32'h0};
    tv[10] = '{4'b0000, 32'h0,  32'h0, 32'h0, 32'h0,    6'b000000, 32'h4,  32'h1234,     32'h0};
    tv[11] = '{4'b1010, 32'h20, 32'h0, 32'h24, 32'h0,   6'b000000, 32'h4,  32'h1234,     32'h0};
    tv[12] = '{4'b1010, 32'h20, 32'h0, 32'h24, 32'h0,   6'b100010, 32'h20, 32'h1234,     32'h0};
    tv[13] = '{4'b1010, 32'h20, 32'h0, 32'h24, 32'h0,   6'b001010, 32'h20, 32'hA0000008, 32'h0};
    tv[14] = '{4'b0010, 32'h0,  32'h0, 32'h24, 32'h0,   6'b000000, 32'h20, 32'hA0000008, 32'h0};
    tv[15] = '{4'b0010, 32'h0,  32'h0, 32'h24, 32'h0,   6'b100011, 32'h24, 32'hA0000008, 32'h0};
    tv[16] = '{4'b0010, 32'h0,  32'h0, 32'h24, 32'h0,   6'b000111, 32'h24, 32'hA0000008, 32'hA0000009};
    tv[17] = '{4'b0000, 32'h0,  32'h0, 32'h0, 32'h0,    6'b000001, 32'h24, 32'hA0000008, 32'hA0000009};

    // Directed table on MEM_LAT=1: core read, loader write then core read, contention
    sel3 = 1'b0;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      {c_req, c_we, l_req, l_we} = tv[k].ctl;
      c_addr = tv[k].ca; c_wdata = tv[k].cd; l_addr = tv[k].la; l_wdata = tv[k].ld;
      @(negedge clk);
      check($sformatf("table_%0d", k),
            cv_t'({o_en, o_we, o_addr, o_cack, o_lack, o_busy, o_owner, o_crd, o_lrd}),
            cv_t'({tv[k].fl[5:4], tv[k].ad, tv[k].fl[3:0], tv[k].crd, tv[k].lrd}));
    end

    // Starvation guard: core requests back-to-back, loader held
    do_reset();
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h8;
    ncore = 0; got_l = 1'b0;
    for (int k = 0; k < 60 && !got_l; k++) begin
      @(negedge clk);
      if (o_cack) ncore++;
      if (o_lack) begin
        got_l = 1'b1;
        check("starve_cnt_cleared", cv_t'(u1.u_starve.cnt), cv_t'(0));
      end
      @(posedge clk); #1;
    end
    check("starve_core_txns", cv_t'(ncore), cv_t'(4));
    check("starve_ldr_granted", cv_t'(got_l), cv_t'(1'b1));
    c_req = 1'b0; l_req = 1'b0;
    repeat (4) @(posedge clk);

    // MEM_LAT=3 core read
    sel3 = 1'b1;
    do_reset();
    @(posedge clk); #1 c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("lat3_cyc%0d", k), cv_t'({o_en, o_cack, o_lack, o_busy}),
            cv_t'({k == 1, k == 4, 1'b0, k >= 1}));
      if (k == 4) check("lat3_rdata", cv_t'(o_crd), cv_t'(32'hDEADBEEF));
      @(posedge clk); #1;
      if (k == 4) c_req = 1'b0;
    end

    // Async reset during WAIT, then restart with c_req still high
    @(negedge clk);
    @(posedge clk); #1 c_req = 1'b1; c_addr = 32'h20;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_seq_issue", cv_t'(o_en), cv_t'(1'b1));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_seq_wait", cv_t'({o_en, o_busy}), cv_t'(2'b01));
    #2 rst = 1'b0;
    #1;
    check("rst_async", cv_t'({o_en, o_cack, o_lack, o_busy, o_owner, o_crd, o_lrd}), '0);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_ack", cv_t'({o_cack, o_lack, o_en, o_busy}), '0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_reissue", cv_t'({o_en, o_addr}), cv_t'({1'b1, 32'h20}));
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("rst_after_%0d", k), cv_t'({o_en, o_cack}), cv_t'({1'b0, k == 3}));
      if (k == 3) check("rst_after_rdata", cv_t'(o_crd), cv_t'(32'hA0000008));
    end
    @(posedge clk); #1 c_req = 1'b0;
    repeat (3) @(posedge clk);

    // Randomized traffic on both latencies
    sel3 = 1'b0; do_reset(); run_random(600);
    sel3 = 1'b1; do_reset(); run_random(600);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end
endmodule
